// File: rtl/logicop_exec_ctrl_pkg.sv
// Shared types for the EX-stage logic/shift sequencer: decoder opcode,
// controller state encoding and the default per-cycle shift step.
package logicop_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    logicop_nop = 3'd0,
    logicop_and = 3'd1,
    logicop_orr = 3'd2,
    logicop_xor = 3'd3,
    logicop_sll = 3'd4,
    logicop_srl = 3'd5,
    logicop_sra = 3'd6
  } rv32_logicop;

  typedef enum logic [1:0] {
    LCE_IDLE  = 2'd0,
    LCE_SHIFT = 2'd1,
    LCE_DONE  = 2'd2
  } lce_state_t;

  localparam int unsigned LOGICOP_SHIFT_STEP_DEFAULT = 4;

  function automatic logic is_shift(input rv32_logicop op);
    return (op == logicop_sll) || (op == logicop_srl) || (op == logicop_sra);
  endfunction

endpackage

// File: rtl/logicop_step_shifter.sv
// One iteration of the multi-cycle shifter: shifts acc by at most SHIFT_STEP
// positions in the direction/fill selected by op.
module logicop_step_shifter
  import logicop_exec_ctrl_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = LOGICOP_SHIFT_STEP_DEFAULT
) (
  input  logic [31:0]                 acc,
  input  logic [$clog2(SHIFT_STEP):0] amount,
  input  rv32_logicop                 op,
  output logic [31:0]                 shifted
);

  always_comb begin
    shifted = acc;
    case (op)
      logicop_sll: shifted = acc << amount;
      logicop_srl: shifted = acc >> amount;
      logicop_sra: shifted = 32'($signed(acc) >>> amount);
      default:     shifted = acc;
    endcase
  end

endmodule

// File: rtl/logicop_exec_ctrl.sv
// EX-stage logic/shift sequencer: bitwise ops finish in one cycle, shifts
// iterate SHIFT_STEP positions per cycle behind valid/ready handshakes.
module logicop_exec_ctrl
  import logicop_exec_ctrl_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = LOGICOP_SHIFT_STEP_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  rv32_logicop i_logicop,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(SHIFT_STEP) + 1;

  lce_state_t  state;
  logic [31:0] acc;
  logic [4:0]  rem;
  rv32_logicop op;

  logic [AW-1:0] step_amt;
  logic [4:0]    rem_next;
  logic [31:0]   acc_shifted;
  logic [31:0]   direct_res;
  logic [4:0]    shamt_in;

  assign shamt_in = i_op_b[4:0];

  always_comb begin
    step_amt = (32'(rem) >= SHIFT_STEP) ? AW'(SHIFT_STEP) : AW'(rem);
    rem_next = rem - 5'(step_amt);
  end

  // Ops that never enter SHIFT; a shift only lands here with shamt == 0.
  always_comb begin
    direct_res = '0;
    case (i_logicop)
      logicop_and: direct_res = i_op_a & i_op_b;
      logicop_orr: direct_res = i_op_a | i_op_b;
      logicop_xor: direct_res = i_op_a ^ i_op_b;
      logicop_sll,
      logicop_srl,
      logicop_sra: direct_res = i_op_a;
      default:     direct_res = '0;
    endcase
  end

  logicop_step_shifter #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_step_shifter (
    .acc    (acc),
    .amount (step_amt),
    .op     (op),
    .shifted(acc_shifted)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= LCE_IDLE;
      acc   <= '0;
      rem   <= '0;
      op    <= logicop_nop;
    end else if (i_flush) begin
      state <= LCE_IDLE;
      acc   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        LCE_IDLE: begin
          if (i_valid) begin
            op <= i_logicop;
            if (is_shift(i_logicop) && (shamt_in != 5'd0)) begin
              acc   <= i_op_a;
              rem   <= shamt_in;
              state <= LCE_SHIFT;
            end else begin
              acc   <= direct_res;
              rem   <= '0;
              state <= LCE_DONE;
            end
          end
        end
        LCE_SHIFT: begin
          acc <= acc_shifted;
          rem <= rem_next;
          if (rem_next == 5'd0) state <= LCE_DONE;
        end
        LCE_DONE: begin
          if (i_ready) begin
            acc   <= '0;
            state <= LCE_IDLE;
          end
        end
        default: state <= LCE_IDLE;
      endcase
    end
  end

  assign o_valid  = (state == LCE_DONE);
  assign o_result = o_valid ? acc : '0;
  assign o_busy   = (state != LCE_IDLE);
  assign o_ready  = (state == LCE_IDLE) && !i_flush;

endmodule

// File: tb/tb_logicop_exec_ctrl.sv
// Directed scoreboard bench for logicop_exec_ctrl with a bit-serial reference model.
module tb_logicop_exec_ctrl;
  import logicop_exec_ctrl_pkg::*;

  localparam int unsigned STEP = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  rv32_logicop i_logicop;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  logicop_exec_ctrl #(
    .SHIFT_STEP(STEP)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_logicop(i_logicop),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] model(input rv32_logicop op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] r;
    int unsigned sh;
    sh = b[4:0];
    r  = a;
    case (op)
      logicop_and: r = a & b;
      logicop_orr: r = a | b;
      logicop_xor: r = a ^ b;
      logicop_sll: for (int unsigned i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      logicop_srl: for (int unsigned i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      logicop_sra: for (int unsigned i = 0; i < sh; i++) r = {r[31], r[31:1]};
      default:     r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input rv32_logicop op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((op == logicop_sll || op == logicop_srl || op == logicop_sra) && sh != 0)
      return 1 + (sh + int'(STEP) - 1) / int'(STEP);
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge following acceptance.
  task automatic send(input rv32_logicop op, input logic [31:0] a, input logic [31:0] b,
                      input bit push);
    i_valid   = 1'b1;
    i_logicop = op;
    i_op_a    = a;
    i_op_b    = b;
    check("accept_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid   = 1'b0;
    i_logicop = rv32_logicop'(3'($urandom_range(0, 7)));
    i_op_a    = $urandom;
    i_op_b    = $urandom;
    if (push) begin
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_latency(op, b));
    end
  endtask

  task automatic recv(input int hold);
    int lat;
    logic [31:0] exp;
    int exp_lat;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    exp     = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", o_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_result", o_result, exp);
      check("hold_ready", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check("post_valid", 32'(o_valid), 32'd0);
    check("post_ready", 32'(o_ready), 32'd1);
    check("post_result", o_result, 32'd0);
  endtask

  initial begin
    int seen;
    checks    = 0;
    errors    = 0;
    i_rst_n   = 1'b0;
    i_flush   = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    i_logicop = logicop_nop;
    i_op_a    = '0;
    i_op_b    = '0;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    send(logicop_and, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    recv(5);
    send(logicop_sra, 32'h8000_0000, 32'h0000_001F, 1'b1);
    recv(0);
    send(logicop_srl, 32'h8000_0000, 32'h0000_0005, 1'b1);
    recv(0);
    send(logicop_sll, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b1);
    recv(0);
    send(logicop_orr, 32'h1234_0000, 32'h0000_5678, 1'b1);
    recv(1);
    send(logicop_xor, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1);
    recv(0);
    send(logicop_nop, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    recv(0);
    send(rv32_logicop'(3'd7), 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    recv(0);
    send(logicop_sra, 32'h8765_4321, 32'h0000_0004, 1'b1);
    recv(0);
    send(logicop_sll, 32'h0000_0001, 32'h0000_001F, 1'b1);
    recv(0);
    for (int k = 0; k < 4; k++) begin
      send(rv32_logicop'(3'($urandom_range(1, 6))), $urandom, $urandom, 1'b1);
      recv(0);
    end

    // Flush during the second SHIFT cycle, with a competing request.
    send(logicop_srl, 32'hFFFF_FFFF, 32'h0000_0014, 1'b0);
    @(negedge i_clk);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_logicop = logicop_and;
    check("flush_busy", 32'(o_busy), 32'd1);
    check("flush_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_idle", 32'(o_busy), 32'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_valid) seen++;
      @(negedge i_clk);
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    send(logicop_srl, 32'h8000_0000, 32'h0000_0005, 1'b1);
    recv(0);

    // Asynchronous reset in the middle of a shift.
    send(logicop_sra, 32'h8000_0000, 32'h0000_001F, 1'b0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_result", o_result, 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("arst_after_valid", 32'(o_valid), 32'd0);
    send(logicop_xor, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b1);
    recv(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
